// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, each with
// a single registered response slot that may drain and reload in the same cycle.
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int CTRL_W = 4,
   parameter int FIRST_PRIO = 0,
   parameter logic [CTRL_W-1:0] IDLE_OP = 4'b1111
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_0,
   input  logic              req_valid_1,
   output logic              req_ready_0,
   output logic              req_ready_1,
   input  logic [WIDTH-1:0]  req_a_0,
   input  logic [WIDTH-1:0]  req_a_1,
   input  logic [WIDTH-1:0]  req_b_0,
   input  logic [WIDTH-1:0]  req_b_1,
   input  logic [CTRL_W-1:0] req_ctrl_0,
   input  logic [CTRL_W-1:0] req_ctrl_1,
   input  logic [1:0]        req_cmp_0,
   input  logic [1:0]        req_cmp_1,
   output logic              rsp_valid_0,
   output logic              rsp_valid_1,
   input  logic              rsp_ready_0,
   input  logic              rsp_ready_1,
   output logic [WIDTH-1:0]  rsp_result_0,
   output logic [WIDTH-1:0]  rsp_result_1,
   output logic              rsp_zero_0,
   output logic              rsp_zero_1,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [CTRL_W-1:0] alu_control,
   output logic [1:0]        alu_cmp,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero
);

   logic             elig_0;
   logic             elig_1;
   logic             grant_0;
   logic             grant_1;
   logic             prio;
   logic             vld_p1_0;
   logic             vld_p1_1;
   logic [WIDTH-1:0] result_p1_0;
   logic [WIDTH-1:0] result_p1_1;
   logic             zero_p1_0;
   logic             zero_p1_1;

   // Stage p0: eligibility and grant; a slot that drains this cycle counts as free.
   always_comb begin
      elig_0  = req_valid_0 && (!vld_p1_0 || rsp_ready_0);
      elig_1  = req_valid_1 && (!vld_p1_1 || rsp_ready_1);
      grant_0 = elig_0 && (!elig_1 || (prio == 1'b0));
      grant_1 = elig_1 && (!elig_0 || (prio == 1'b1));
   end

   assign req_ready_0 = grant_0;
   assign req_ready_1 = grant_1;

   always_comb begin
      alu_a       = '0;
      alu_b       = '0;
      alu_control = IDLE_OP;
      alu_cmp     = 2'b00;
      if (grant_0) begin
         alu_a       = req_a_0;
         alu_b       = req_b_0;
         alu_control = req_ctrl_0;
         alu_cmp     = req_cmp_0;
      end else if (grant_1) begin
         alu_a       = req_a_1;
         alu_b       = req_b_1;
         alu_control = req_ctrl_1;
         alu_cmp     = req_cmp_1;
      end
   end

   // Pointer names the requester that wins the next contended cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= 1'(FIRST_PRIO);
      end else if (elig_0 && elig_1) begin
         prio <= grant_0;
      end
   end

   // Stage p1: response slots, loaded on grant, cleared when consumed without reload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_0    <= 1'b0;
         result_p1_0 <= '0;
         zero_p1_0   <= 1'b0;
      end else if (grant_0) begin
         vld_p1_0    <= 1'b1;
         result_p1_0 <= alu_result;
         zero_p1_0   <= alu_zero;
      end else if (rsp_ready_0) begin
         vld_p1_0    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_1    <= 1'b0;
         result_p1_1 <= '0;
         zero_p1_1   <= 1'b0;
      end else if (grant_1) begin
         vld_p1_1    <= 1'b1;
         result_p1_1 <= alu_result;
         zero_p1_1   <= alu_zero;
      end else if (rsp_ready_1) begin
         vld_p1_1    <= 1'b0;
      end
   end

   assign rsp_valid_0  = vld_p1_0;
   assign rsp_valid_1  = vld_p1_1;
   assign rsp_result_0 = result_p1_0;
   assign rsp_result_1 = result_p1_1;
   assign rsp_zero_0   = zero_p1_0;
   assign rsp_zero_1   = zero_p1_1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached.
module tb_alu_share_arbiter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid_0, req_valid_1;
   logic          req_ready_0, req_ready_1;
   logic [W-1:0]  req_a_0, req_a_1, req_b_0, req_b_1;
   logic [3:0]    req_ctrl_0, req_ctrl_1;
   logic [1:0]    req_cmp_0, req_cmp_1;
   logic          rsp_valid_0, rsp_valid_1;
   logic          rsp_ready_0, rsp_ready_1;
   logic [W-1:0]  rsp_result_0, rsp_result_1;
   logic          rsp_zero_0, rsp_zero_1;
   logic [W-1:0]  alu_a, alu_b;
   logic [3:0]    alu_control;
   logic [1:0]    alu_cmp;
   logic [W-1:0]  alu_result;
   logic          alu_zero;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_XOR = 4'd3,
                          OP_SLL = 4'd4, OP_SLT = 4'd5, OP_SUB = 4'd6, OP_SLTU = 4'd7,
                          OP_SRL = 4'd8, OP_SRA = 4'd9;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(W), .CTRL_W(4), .FIRST_PRIO(0), .IDLE_OP(4'b1111)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
      .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
      .req_cmp_0(req_cmp_0), .req_cmp_1(req_cmp_1),
      .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
      .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
      .rsp_result_0(rsp_result_0), .rsp_result_1(rsp_result_1),
      .rsp_zero_0(rsp_zero_0), .rsp_zero_1(rsp_zero_1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_cmp(alu_cmp),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   // Behavioural ALU; unknown codes (including the idle code) give 0.
   always_comb begin
      alu_result = '0;
      case (alu_control)
         OP_AND:  alu_result = alu_a & alu_b;
         OP_OR:   alu_result = alu_a | alu_b;
         OP_ADD:  alu_result = alu_a + alu_b;
         OP_XOR:  alu_result = alu_a ^ alu_b;
         OP_SLL:  alu_result = alu_a << alu_b[4:0];
         OP_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         OP_SUB:  alu_result = alu_a - alu_b;
         OP_SLTU: alu_result = {31'd0, alu_a < alu_b};
         OP_SRL:  alu_result = alu_a >> alu_b[4:0];
         OP_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [1:0] cmp);
      req_valid_0 = v; req_ctrl_0 = op; req_a_0 = a; req_b_0 = b; req_cmp_0 = cmp;
   endtask

   task automatic set_req1(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [1:0] cmp);
      req_valid_1 = v; req_ctrl_1 = op; req_a_1 = a; req_b_1 = b; req_cmp_1 = cmp;
   endtask

   initial begin
      rst_n = 1'b0;
      set_req0(1'b0, OP_AND, '0, '0, 2'b00);
      set_req1(1'b0, OP_AND, '0, '0, 2'b00);
      rsp_ready_0 = 1'b0;
      rsp_ready_1 = 1'b0;
      #3;
      check("rst_vld0", rsp_valid_0, 0);
      check("rst_vld1", rsp_valid_1, 0);
      check("rst_res0", rsp_result_0, 0);
      check("rst_zero1", rsp_zero_1, 0);
      check("rst_idle_op", alu_control, 4'hF);
      #7 rst_n = 1'b1;
      tick();

      // Single requester ADD 5+7
      set_req0(1'b1, OP_ADD, 5, 7, 2'b00);
      #1;
      check("add_ready0", req_ready_0, 1);
      check("add_ready1", req_ready_1, 0);
      check("add_alu_a", alu_a, 5);
      check("add_alu_ctrl", alu_control, OP_ADD);
      tick();
      req_valid_0 = 1'b0;
      check("add_vld0", rsp_valid_0, 1);
      check("add_res0", rsp_result_0, 12);
      check("add_zero0", rsp_zero_0, 0);
      tick();
      check("add_hold_vld0", rsp_valid_0, 1);
      rsp_ready_0 = 1'b1;
      tick();
      check("add_drained", rsp_valid_0, 0);

      // Both streaming, grants alternate starting with 0
      set_req0(1'b1, OP_SUB, 9, 9, 2'b00);
      set_req1(1'b1, OP_OR, 32'hF0, 32'h0F, 2'b00);
      rsp_ready_0 = 1'b1;
      rsp_ready_1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("alt_ready0_%0d", i), req_ready_0, (i % 2 == 0) ? 1 : 0);
         check($sformatf("alt_ready1_%0d", i), req_ready_1, (i % 2 == 1) ? 1 : 0);
         tick();
         if (i % 2 == 0) begin
            check("alt_res0", rsp_result_0, 0);
            check("alt_zero0", rsp_zero_0, 1);
         end else begin
            check("alt_res1", rsp_result_1, 32'hFF);
            check("alt_zero1", rsp_zero_1, 0);
         end
      end
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b0;
      tick();
      check("alt_drain0", rsp_valid_0, 0);
      check("alt_drain1", rsp_valid_1, 0);

      // Backpressure on requester 0 while requester 1 streams
      set_req0(1'b1, OP_ADD, 1, 1, 2'b00);
      set_req1(1'b1, OP_ADD, 2, 3, 2'b00);
      rsp_ready_0 = 1'b0;
      #1;
      check("bp_first_ready0", req_ready_0, 1);
      tick();
      check("bp_res0", rsp_result_0, 2);
      for (int i = 0; i < 3; i++) begin
         set_req1(1'b1, OP_ADD, 10 + i, 1, 2'b00);
         #1;
         check("bp_ready0", req_ready_0, 0);
         check("bp_ready1", req_ready_1, 1);
         tick();
         check("bp_res1", rsp_result_1, 11 + i);
         check("bp_hold_res0", rsp_result_0, 2);
         check("bp_hold_vld0", rsp_valid_0, 1);
      end
      rsp_ready_0 = 1'b1;
      #1;
      check("bp_pulse_ready0", req_ready_0, 0);
      check("bp_pulse_ready1", req_ready_1, 1);
      tick();
      check("bp_pulse_drain0", rsp_valid_0, 0);
      #1;
      check("bp_after_ready0", req_ready_0, 1);
      check("bp_after_ready1", req_ready_1, 0);
      tick();
      check("bp_after_vld0", rsp_valid_0, 1);
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b0;
      tick();
      check("bp_drain0", rsp_valid_0, 0);
      check("bp_drain1", rsp_valid_1, 0);

      // Same-cycle drain and reload on requester 0
      set_req0(1'b1, OP_XOR, 3, 3, 2'b11);
      #1;
      check("rl_alu_cmp", alu_cmp, 2'b11);
      tick();
      check("rl_vld_a", rsp_valid_0, 1);
      check("rl_zero_a", rsp_zero_0, 1);
      set_req0(1'b1, OP_XOR, 3, 1, 2'b11);
      #1;
      check("rl_ready_b", req_ready_0, 1);
      tick();
      check("rl_vld_b", rsp_valid_0, 1);
      check("rl_res_b", rsp_result_0, 2);
      check("rl_zero_b", rsp_zero_0, 0);
      set_req0(1'b1, OP_XOR, 3, 3, 2'b11);
      tick();
      check("rl_vld_c", rsp_valid_0, 1);
      check("rl_res_c", rsp_result_0, 0);
      check("rl_zero_c", rsp_zero_0, 1);
      req_valid_0 = 1'b0;
      tick();
      check("rl_drain", rsp_valid_0, 0);

      // Idle
      #1;
      check("idle_ctrl", alu_control, 4'hF);
      check("idle_a", alu_a, 0);
      check("idle_b", alu_b, 0);
      check("idle_cmp", alu_cmp, 0);
      check("idle_ready0", req_ready_0, 0);
      tick();
      check("idle_vld0", rsp_valid_0, 0);
      check("idle_vld1", rsp_valid_1, 0);

      // Asynchronous reset with a held response in slot 1
      set_req1(1'b1, OP_ADD, 4, 4, 2'b00);
      rsp_ready_1 = 1'b0;
      tick();
      req_valid_1 = 1'b0;
      check("ar_vld1", rsp_valid_1, 1);
      check("ar_res1", rsp_result_1, 8);
      #2 rst_n = 1'b0;
      #1;
      check("ar_vld1_cleared", rsp_valid_1, 0);
      check("ar_res1_cleared", rsp_result_1, 0);
      #1 rst_n = 1'b1;
      set_req0(1'b1, OP_ADD, 1, 2, 2'b00);
      set_req1(1'b1, OP_ADD, 3, 4, 2'b00);
      rsp_ready_1 = 1'b1;
      #1;
      check("ar_first_ready0", req_ready_0, 1);
      check("ar_first_ready1", req_ready_1, 0);
      tick();
      check("ar_first_res0", rsp_result_0, 3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (AND/OR/ADD/XOR/SLL/SLT/SUB/SLTU/SRL/SRA, with a compare-enable and an equal/inequal sense select) between two requesters.
  - Requester 0: execute-stage datapath.
  - Requester 1: address/CSR helper unit.
- Round-robin arbitration per cycle, valid/ready request and response handshakes, one registered response slot per requester.
- Sits between the requesters and the ALU instance; the ALU itself stays purely combinational.

Parameters:
- WIDTH, 32, operand/result width.
- CTRL_W, 4, ALU operation code width.
- FIRST_PRIO, 0, requester that wins the first contended cycle after reset (0 or 1).
- IDLE_OP, 4'b1111, operation code driven to the ALU when no grant (ALU default case, result 0).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_0 / req_valid_1  in  1  request present
- req_ready_0 / req_ready_1  out  1  request accepted this cycle (grant)
- req_a_0 / req_a_1  in  WIDTH  operand A
- req_b_0 / req_b_1  in  WIDTH  operand B
- req_ctrl_0 / req_ctrl_1  in  CTRL_W  ALU operation code
- req_cmp_0 / req_cmp_1  in  2  {equal_inequal, comparator_enable}
- rsp_valid_0 / rsp_valid_1  out  1  response slot holds result
- rsp_ready_0 / rsp_ready_1  in  1  requester consumes response
- rsp_result_0 / rsp_result_1  out  WIDTH  captured ALU result
- rsp_zero_0 / rsp_zero_1  out  1  captured ALU zero flag
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_control  out  CTRL_W  ALU operation code
- alu_cmp  out  2  {equal_inequal, comparator_enable} to ALU
- alu_result  in  WIDTH  ALU result, combinational, same cycle
- alu_zero  in  1  ALU zero flag, combinational, same cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid_x=0, rsp_result_x=0, rsp_zero_x=0.
  - Priority pointer set so FIRST_PRIO wins the next contended cycle.
  - Reset takes effect mid-transaction; any pending response is discarded.
- Eligibility: elig_x = req_valid_x && (!rsp_valid_x || rsp_ready_x), i.e. the slot is free or drains this same cycle.
- Grant (combinational, at most one per cycle):
  - Only one requester eligible: it is granted.
  - Both eligible: the requester not granted last time wins. The pointer updates only on a contended grant; an uncontended grant leaves the pointer unchanged.
  - req_ready_x = grant_x. req_ready_x may depend on req_valid_x; requesters must not make valid depend on ready.
- ALU drive:
  - Granted requester's a/b/ctrl/cmp are muxed onto the alu_* outputs.
  - No grant: alu_a=0, alu_b=0, alu_control=IDLE_OP, alu_cmp=2'b00.
- Capture: on a grant, alu_result and alu_zero are registered into that requester's slot at the clock edge. rsp_valid_x=1 the next cycle (latency 1).
- Response slot:
  - Holds result and zero stable while rsp_valid_x=1 and rsp_ready_x=0.
  - rsp_ready_x=1 with no new grant: rsp_valid_x clears next cycle.
  - rsp_ready_x=1 with a new grant in the same cycle: slot reloads, rsp_valid_x stays 1. This gives back-to-back throughput of 1 per cycle per requester when uncontended.
- Backpressure: rsp_valid_x=1 and rsp_ready_x=0 makes requester x ineligible. The other requester may use the ALU every cycle meanwhile.
- Fairness: with both continuously eligible, grants alternate 0,1,0,1,… (starting per FIRST_PRIO). Neither requester waits more than 1 cycle.
- Requests are not stored; a request whose ready stays low must be held stable by its requester.
- Comparator semantics (zero flag meaning for XOR/SLT/SLTU under cmp) belong to the ALU. This block passes cmp through and captures zero unchanged.

Test Plan:
- Reset, then req0 only: ADD a=5 b=7 -> req_ready_0=1 same cycle; next cycle rsp_valid_0=1, rsp_result_0=12, rsp_zero_0=0.
- Both valid every cycle, both rsp_ready=1, FIRST_PRIO=0, req0 SUB 9-9 and req1 OR 0xF0|0x0F -> grants alternate 0,1,0,…; rsp_zero_0=1 with result 0; rsp_result_1=0xFF.
- Backpressure: req0 rsp_ready_0=0 after its first result, req1 streaming -> req1 granted every cycle; rsp_result_0 held constant; req_ready_0=0 until rsp_ready_0 pulses.
- Same-cycle drain and reload: req0 XOR a=3 b=3 cmp=2'b11 with rsp_ready_0=1 on consecutive cycles -> rsp_valid_0 stays 1, new result each cycle, rsp_zero_0=1.
- Idle: no req_valid -> alu_control=4'b1111, alu_a=alu_b=0, no rsp_valid change.
- Async reset while rsp_valid_1=1 -> rsp_valid_1 drops immediately without a clock edge; first contended grant after release goes to FIRST_PRIO.
